// File: rtl/windowed_register_file.sv
// SPARC V8 style windowed integer register file: 7 stored globals plus NWIN
// overlapping 16-word windows, two combinational read ports, one write port, CWP control.
module windowed_register_file #(
    parameter int NWIN = 4,
    parameter int CWPW = 2
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [31:0]     rs1_data,
    output logic [31:0]     rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [31:0]     rd_data,
    input  logic            save,
    input  logic            restore,
    input  logic            cwp_load,
    input  logic [CWPW-1:0] cwp_in,
    input  logic [NWIN-1:0] wim,
    output logic [CWPW-1:0] cwp,
    output logic            trap_ovf,
    output logic            trap_unf,
    output logic            req_err
);

    // %g0 is hardwired, so only g1..g7 occupy storage.
    localparam int NG     = 7;
    localparam int NWORDS = NG + 16 * NWIN;
    localparam int IW     = $clog2(NWORDS);

    logic [31:0]     mem_reg [NWORDS];
    logic [CWPW-1:0] cwp_reg, cwp_next;
    logic            trap_ovf_reg, trap_ovf_next;
    logic            trap_unf_reg, trap_unf_next;
    logic            req_err_reg, req_err_next;
    logic [CWPW-1:0] save_n, restore_n;
    logic            wr_ok;
    logic [IW-1:0]   wr_idx;
    logic [NWORDS-1:0] word_we;

    // Window w: outs at base, locals at base+8; ins are the outs of window w+1.
    function automatic logic [IW-1:0] map_idx(input logic [4:0] r, input logic [CWPW-1:0] w);
        int wi;
        int wn;
        int idx;
        wi = int'(w);
        wn = (wi + 1 >= NWIN) ? 0 : wi + 1;
        if (r < 5'd8)
            idx = int'(r) - 1;
        else if (r < 5'd24)
            idx = NG + 16 * wi + int'(r) - 8;
        else
            idx = NG + 16 * wn + int'(r) - 24;
        return IW'(idx);
    endfunction

    // A cwp_load beyond NWIN-1 would address nonexistent words; such accesses read 0 and drop writes.
    function automatic logic map_ok(input logic [4:0] r, input logic [CWPW-1:0] w);
        return (r != 5'd0) && (int'(w) < NWIN);
    endfunction

    function automatic logic win_invalid(input logic [CWPW-1:0] n);
        return (int'(n) >= NWIN) ? 1'b1 : wim[n];
    endfunction

    assign rs1_data = map_ok(rs1_addr, cwp_reg) ? mem_reg[map_idx(rs1_addr, cwp_reg)] : 32'd0;
    assign rs2_data = map_ok(rs2_addr, cwp_reg) ? mem_reg[map_idx(rs2_addr, cwp_reg)] : 32'd0;

    // Write decodes with the pre-change cwp, so a same-cycle SAVE cannot redirect it.
    assign wr_ok  = we && map_ok(rd_addr, cwp_reg);
    assign wr_idx = map_idx(rd_addr, cwp_reg);

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word_we
            assign word_we[gi] = wr_ok && (wr_idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NWORDS; i++)
                mem_reg[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NWORDS; i++)
                if (word_we[i])
                    mem_reg[i] <= rd_data;
        end
    end

    assign save_n    = (cwp_reg == '0) ? CWPW'(NWIN - 1) : cwp_reg - CWPW'(1);
    assign restore_n = (cwp_reg == CWPW'(NWIN - 1)) ? '0 : cwp_reg + CWPW'(1);

    always_comb begin
        cwp_next      = cwp_reg;
        trap_ovf_next = 1'b0;
        trap_unf_next = 1'b0;
        req_err_next  = 1'b0;
        if (cwp_load) begin
            cwp_next = cwp_in;
        end else if (save && restore) begin
            req_err_next = 1'b1;
        end else if (save) begin
            if (win_invalid(save_n))
                trap_ovf_next = 1'b1;
            else
                cwp_next = save_n;
        end else if (restore) begin
            if (win_invalid(restore_n))
                trap_unf_next = 1'b1;
            else
                cwp_next = restore_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            cwp_reg      <= '0;
            trap_ovf_reg <= 1'b0;
            trap_unf_reg <= 1'b0;
            req_err_reg  <= 1'b0;
        end else begin
            cwp_reg      <= cwp_next;
            trap_ovf_reg <= trap_ovf_next;
            trap_unf_reg <= trap_unf_next;
            req_err_reg  <= req_err_next;
        end
    end

    assign cwp      = cwp_reg;
    assign trap_ovf = trap_ovf_reg;
    assign trap_unf = trap_unf_reg;
    assign req_err  = req_err_reg;

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed bench for windowed_register_file (NWIN=4): reset, mapping, window
// aliasing, wrap-around, traps, request conflicts, reload and reset priority.
module tb_windowed_register_file;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        we, save, restore, cwp_load;
    logic [1:0]  cwp_in, cwp;
    logic [3:0]  wim;
    logic        trap_ovf, trap_unf, req_err;

    int total = 0;
    int bad   = 0;

    windowed_register_file #(.NWIN(4), .CWPW(2)) dut (
        .Clk(Clk), .Clr(Clr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .save(save), .restore(restore),
        .cwp_load(cwp_load), .cwp_in(cwp_in), .wim(wim),
        .cwp(cwp), .trap_ovf(trap_ovf), .trap_unf(trap_unf), .req_err(req_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow after a settle delay.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        we = 1'b1; rd_addr = r; rd_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] r, input logic [31:0] exp);
        rs1_addr = r; rs2_addr = r;
        #1;
        chk({tag, "_a"}, rs1_data, exp);
        chk({tag, "_b"}, rs2_data, exp);
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] ecwp,
                             input logic eovf, input logic eunf, input logic eerr);
        chk({tag, "_cwp"}, 32'(cwp), 32'(ecwp));
        chk({tag, "_ovf"}, 32'(trap_ovf), 32'(eovf));
        chk({tag, "_unf"}, 32'(trap_unf), 32'(eunf));
        chk({tag, "_err"}, 32'(req_err), 32'(eerr));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r); rs2_addr = 5'(31 - r);
            #1;
            chk({tag, "_a"}, rs1_data, 32'd0);
            chk({tag, "_b"}, rs2_data, 32'd0);
        end
    endtask

    initial begin
        Clr = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0; save = 1'b0; restore = 1'b0;
        cwp_load = 1'b0; cwp_in = '0; wim = '0;

        // Reset state
        tick();
        Clr = 1'b0;
        chk_flags("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_all_zero("rst_rd");

        // Basic write/read in window 0; r0 discards writes
        wr(5'd9, 32'h11);
        wr(5'd17, 32'h22);
        wr(5'd1, 32'h33);
        rdchk("r9", 5'd9, 32'h11);
        rdchk("r17", 5'd17, 32'h22);
        rdchk("r1", 5'd1, 32'h33);
        wr(5'd0, 32'hFF);
        rdchk("r0", 5'd0, 32'h0);

        // SAVE wraps 0 -> 3; window 3 ins alias window 0 outs
        wr(5'd8, 32'hA5A5A5A5);
        save = 1'b1; tick(); save = 1'b0;
        chk_flags("save_wrap", 2'd3, 1'b0, 1'b0, 1'b0);
        rdchk("w3_r24", 5'd24, 32'hA5A5A5A5);
        rdchk("w3_r25", 5'd25, 32'h11);
        rdchk("w3_r8", 5'd8, 32'h0);
        rdchk("w3_r1", 5'd1, 32'h33);
        // RESTORE wraps 3 -> 0
        restore = 1'b1; tick(); restore = 1'b0;
        chk_flags("rest_wrap", 2'd0, 1'b0, 1'b0, 1'b0);
        rdchk("w0_r8", 5'd8, 32'hA5A5A5A5);
        rdchk("w0_r17", 5'd17, 32'h22);

        // Overflow trap: target window 3 invalid
        wim = 4'b1000; save = 1'b1; tick(); save = 1'b0;
        chk_flags("ovf", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("ovf_clr", 2'd0, 1'b0, 1'b0, 1'b0);
        // Underflow trap: target window 1 invalid
        wim = 4'b0010; restore = 1'b1; tick(); restore = 1'b0;
        chk_flags("unf", 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_flags("unf_clr", 2'd0, 1'b0, 1'b0, 1'b0);
        wim = 4'b0000;

        // No write bypass
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'h7; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk("nobyp_old", rs1_data, 32'h0);
        tick(); we = 1'b0;
        chk("nobyp_new", rs1_data, 32'h7);

        // Simultaneous save+restore
        save = 1'b1; restore = 1'b1; tick(); save = 1'b0; restore = 1'b0;
        chk_flags("both", 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_flags("both_clr", 2'd0, 1'b0, 1'b0, 1'b0);

        // Write decodes with old cwp during SAVE
        we = 1'b1; rd_addr = 5'd8; rd_data = 32'h55; save = 1'b1;
        tick(); we = 1'b0; save = 1'b0;
        chk_flags("wr_save", 2'd3, 1'b0, 1'b0, 1'b0);
        rdchk("wrsave_r24", 5'd24, 32'h55);
        rdchk("wrsave_r8", 5'd8, 32'h0);

        // cwp_load beats a save that would otherwise trap (target 2 invalid)
        wim = 4'b0100; cwp_load = 1'b1; cwp_in = 2'd2; save = 1'b1;
        tick(); cwp_load = 1'b0; save = 1'b0;
        chk_flags("load", 2'd2, 1'b0, 1'b0, 1'b0);
        rdchk("load_r24", 5'd24, 32'h0);
        cwp_load = 1'b1; cwp_in = 2'd0; tick(); cwp_load = 1'b0;
        chk_flags("load0", 2'd0, 1'b0, 1'b0, 1'b0);
        rdchk("load_r8", 5'd8, 32'h55);
        rdchk("load_r5", 5'd5, 32'h7);

        // Clr beats a trapping save and a write
        cwp_load = 1'b1; cwp_in = 2'd2; tick(); cwp_load = 1'b0;
        wim = 4'b0010; save = 1'b1; we = 1'b1; rd_addr = 5'd9; rd_data = 32'hFFFF; Clr = 1'b1;
        tick();
        Clr = 1'b0; save = 1'b0; we = 1'b0; wim = 4'b0000;
        chk_flags("clr_save", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_all_zero("clr_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
